rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Power-on reset/clock-enable sequencer for N_DOM domains with
// PLL-lock qualification and per-domain software reset handshake.
module rst_seq_ctrl #(
    parameter int N_DOM      = 3,
    parameter int SETTLE_CYC = 16,
    parameter int GAP_CYC    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             pll_lock_i,
    input  logic [N_DOM-1:0] sw_rst_req_i,
    output logic [N_DOM-1:0] sw_rst_ack_o,
    output logic [N_DOM-1:0] clk_en_o,
    output logic [N_DOM-1:0] rst_n_o,
    output logic             seq_done_o,
    output logic [2:0]       state_o
);

    localparam int KW = $clog2(N_DOM + 1);
    localparam int SW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [KW-1:0]    K_END       = KW'(N_DOM);

    if (N_DOM < 1) begin : g_bad_ndom
        $error("rst_seq_ctrl: N_DOM must be at least 1");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > (1 << CNT_W) - 1) begin : g_bad_settle
        $error("rst_seq_ctrl: SETTLE_CYC out of range for CNT_W");
    end
    if (GAP_CYC < 1 || GAP_CYC > (1 << CNT_W) - 1) begin : g_bad_gap
        $error("rst_seq_ctrl: GAP_CYC out of range for CNT_W");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        SWRST   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [N_DOM-1:0] clk_en_q, clk_en_d;
    logic [N_DOM-1:0] rst_q, rst_d;
    logic [N_DOM-1:0] ack_q, ack_d;
    logic             done_q, done_d;
    logic [N_DOM-1:0] pending;
    logic [SW-1:0]    pick;
    logic             pick_vld;

    // Lowest-index request that has not yet been acknowledged.
    always_comb begin
        pending  = sw_rst_req_i & ~ack_q;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick     = SW'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        sel_d    = sel_q;
        clk_en_d = clk_en_q;
        rst_d    = rst_q;
        ack_d    = ack_q & sw_rst_req_i;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                clk_en_d = '0;
                rst_d    = '0;
                done_d   = 1'b0;
                if (pll_lock_i) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = RELEASE;
                    cnt_d       = '0;
                    k_d         = '0;
                    clk_en_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (k_q == K_END) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    for (int i = 0; i < N_DOM; i++) begin
                        if (i == int'(k_q)) begin
                            rst_d[i] = 1'b1;
                        end
                        if (i == int'(k_q) + 1) begin
                            clk_en_d[i] = 1'b1;
                        end
                    end
                    k_d   = k_q + 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (pick_vld) begin
                    state_d = SWRST;
                    sel_d   = pick;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    for (int i = 0; i < N_DOM; i++) begin
                        if (i == int'(pick)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                end
            end
            SWRST: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                    for (int i = 0; i < N_DOM; i++) begin
                        if (i == int'(sel_q)) begin
                            rst_d[i] = 1'b1;
                            ack_d[i] = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Lock loss overrides everything above.
        if (state_q != IDLE && !pll_lock_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            k_d      = '0;
            clk_en_d = '0;
            rst_d    = '0;
            ack_d    = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            sel_q    <= '0;
            clk_en_q <= '0;
            rst_q    <= '0;
            ack_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            sel_q    <= sel_d;
            clk_en_q <= clk_en_d;
            rst_q    <= rst_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
        end
    end

    assign sw_rst_ack_o = ack_q;
    assign clk_en_o     = clk_en_q;
    assign rst_n_o      = rst_q;
    assign seq_done_o   = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (N_DOM=3, SETTLE_CYC=16, GAP_CYC=8).
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic [2:0] req;
    logic [2:0] ack;
    logic [2:0] clk_en;
    logic [2:0] rst_o;
    logic       done;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    rst_seq_ctrl #(
        .N_DOM(3),
        .SETTLE_CYC(16),
        .GAP_CYC(8),
        .CNT_W(8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .pll_lock_i(lock),
        .sw_rst_req_i(req),
        .sw_rst_ack_o(ack),
        .clk_en_o(clk_en),
        .rst_n_o(rst_o),
        .seq_done_o(done),
        .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] s,
                            input logic [2:0] ce, input logic [2:0] rn,
                            input logic [2:0] ak, input logic dn);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".clk_en"}, 32'(clk_en), 32'(ce));
        chk({tag, ".rst_n"}, 32'(rst_o), 32'(rn));
        chk({tag, ".ack"}, 32'(ack), 32'(ak));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    // Lock must already be high before the next edge (edge E).
    // partial=1 stops just after E+24 while still in RELEASE.
    task automatic power_seq(input string tag, input bit partial);
        step(1);
        chk_outs({tag, "@E"}, 3'd1, 3'b000, 3'b000, 3'b000, 1'b0);
        step(15);
        chk_outs({tag, "@E+15"}, 3'd1, 3'b000, 3'b000, 3'b000, 1'b0);
        step(1);
        chk_outs({tag, "@E+16"}, 3'd2, 3'b001, 3'b000, 3'b000, 1'b0);
        step(7);
        chk_outs({tag, "@E+23"}, 3'd2, 3'b001, 3'b000, 3'b000, 1'b0);
        step(1);
        chk_outs({tag, "@E+24"}, 3'd2, 3'b011, 3'b001, 3'b000, 1'b0);
        if (!partial) begin
            step(8);
            chk_outs({tag, "@E+32"}, 3'd2, 3'b111, 3'b011, 3'b000, 1'b0);
            step(8);
            chk_outs({tag, "@E+40"}, 3'd2, 3'b111, 3'b111, 3'b000, 1'b0);
            step(1);
            chk_outs({tag, "@E+41"}, 3'd3, 3'b111, 3'b111, 3'b000, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lock  = 1'b0;
        req   = 3'b000;
        #2;
        chk_outs("reset", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(3);
        chk_outs("idle_nolock", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);

        // Short lock pulse: 10 sampled-high edges, then lost.
        lock = 1'b1;
        step(10);
        chk("pulse.state_settle", 32'(state), 32'd1);
        lock = 1'b0;
        step(1);
        chk_outs("pulse_lost", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        step(5);
        chk_outs("pulse_idle", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);

        lock = 1'b1;
        power_seq("seq1", 1'b0);

        // Two requests served in index order; domain 0 untouched.
        req = 3'b110;
        step(1);
        chk_outs("sw1_enter", 3'd4, 3'b111, 3'b101, 3'b000, 1'b0);
        step(7);
        chk_outs("sw1_hold", 3'd4, 3'b111, 3'b101, 3'b000, 1'b0);
        step(1);
        chk_outs("sw1_done", 3'd3, 3'b111, 3'b111, 3'b010, 1'b1);
        step(1);
        chk_outs("sw2_enter", 3'd4, 3'b111, 3'b011, 3'b010, 1'b0);
        step(7);
        chk_outs("sw2_hold", 3'd4, 3'b111, 3'b011, 3'b010, 1'b0);
        step(1);
        chk_outs("sw2_done", 3'd3, 3'b111, 3'b111, 3'b110, 1'b1);

        // Ack held while request held: no re-service.
        step(50);
        chk_outs("held50", 3'd3, 3'b111, 3'b111, 3'b110, 1'b1);
        req = 3'b100;
        step(1);
        chk_outs("req1_low", 3'd3, 3'b111, 3'b111, 3'b100, 1'b1);
        req = 3'b110;
        step(1);
        chk_outs("req1_again", 3'd4, 3'b111, 3'b101, 3'b100, 1'b0);
        step(8);
        chk_outs("req1_again_done", 3'd3, 3'b111, 3'b111, 3'b110, 1'b1);
        req = 3'b000;
        step(1);
        chk_outs("all_req_low", 3'd3, 3'b111, 3'b111, 3'b000, 1'b1);

        // Request dropped during SWRST: completes, ack pulses once.
        req = 3'b001;
        step(1);
        chk_outs("sw0_enter", 3'd4, 3'b111, 3'b110, 3'b000, 1'b0);
        req = 3'b000;
        step(8);
        chk_outs("sw0_done", 3'd3, 3'b111, 3'b111, 3'b001, 1'b1);
        step(1);
        chk_outs("sw0_ack_fall", 3'd3, 3'b111, 3'b111, 3'b000, 1'b1);
        step(3);
        chk_outs("sw0_no_reserve", 3'd3, 3'b111, 3'b111, 3'b000, 1'b1);

        // Asynchronous reset in the middle of SWRST.
        req = 3'b001;
        step(1);
        chk("mid_sw.state", 32'(state), 32'd4);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        req = 3'b000;
        step(2);
        rst_n = 1'b1;
        power_seq("seq2_part", 1'b1);

        // Lock lost mid-RELEASE after rst_n_o=001.
        lock = 1'b0;
        step(1);
        chk_outs("lock_drop", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        lock = 1'b1;
        power_seq("seq3", 1'b0);

        // Request raised outside RUN stays pending until RUN.
        lock = 1'b0;
        step(1);
        chk_outs("lock_drop2", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        req  = 3'b100;
        lock = 1'b1;
        power_seq("seq4", 1'b0);
        step(1);
        chk_outs("pend_served", 3'd4, 3'b111, 3'b011, 3'b000, 1'b0);
        step(8);
        chk_outs("pend_done", 3'd3, 3'b111, 3'b111, 3'b100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
